// File: rtl/lc3_gen_pkg.sv
// Shared types for the parametrised LC-3 datapath: mux/ALU selector encodings,
// memory handshake states and the fixed link-register index.
package lc3_gen_pkg;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_AND  = 2'd1,
      ALU_NOT  = 2'd2,
      ALU_PASS = 2'd3
   } aluk_t;

   typedef enum logic [1:0] {
      PC_INC  = 2'd0,
      PC_BUS  = 2'd1,
      PC_ADDR = 2'd2,
      PC_HOLD = 2'd3
   } pcmux_t;

   typedef enum logic [1:0] {
      A2_OFF11 = 2'd0,
      A2_OFF9  = 2'd1,
      A2_OFF6  = 2'd2,
      A2_ZERO  = 2'd3
   } addr2mux_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [2:0] R7 = 3'd7;

endpackage

// File: rtl/lc3_mem_engine.sv
// Memory handshake engine: request/ack sequencing with a bounded wait and a
// sticky timeout flag; tells the datapath when to capture read data into MDR.
module lc3_mem_engine
   import lc3_gen_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_start,
   input  logic mem_we,
   input  logic mem_ack,
   output logic mem_req,
   output logic mem_wr,
   output logic mem_busy,
   output logic mem_done,
   output logic mem_err,
   output logic rd_load
);

   // The counter only has to reach MEM_TIMEOUT-1, the index of the last REQ cycle.
   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

   mem_state_t       state_reg, state_next;
   logic             we_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             err_reg;
   logic             timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         we_reg    <= 1'b0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && mem_start) begin
            we_reg  <= mem_we;
            cnt_reg <= '0;
         end else if (state_reg == REQ) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (timeout)
            err_reg <= 1'b1;
      end
   end

   // An ack arriving on the final wait cycle still wins over the timeout.
   always_comb begin
      state_next = state_reg;
      rd_load    = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: if (mem_start) state_next = REQ;
         REQ: begin
            if (mem_ack) begin
               rd_load    = ~we_reg;
               state_next = DONE;
            end else if (cnt_reg == LAST_WAIT) begin
               timeout    = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign mem_req  = (state_reg == REQ);
   assign mem_wr   = mem_req & we_reg;
   assign mem_busy = (state_reg != IDLE);
   assign mem_done = (state_reg == DONE);
   assign mem_err  = err_reg;

endmodule

// File: rtl/lc3_datapath_gen.sv
// LC-3 datapath generalised to WIDTH bits: PC/IR/MAR/MDR, register file, ALU,
// condition codes, LED latch and the priority bus, with its own memory engine.
module lc3_datapath_gen
   import lc3_gen_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] PC_RESET    = '0,
   parameter int               LED_W       = 12,
   parameter int               MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_CC,
   input  logic             LD_REG,
   input  logic             LD_PC,
   input  logic             LD_LED,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic             ADDR1MUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             DRMUX,
   input  logic [1:0]       ALUK,
   input  logic             mem_start,
   input  logic             mem_we,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             mem_busy,
   output logic             mem_done,
   output logic             mem_err,
   output logic             bus_conflict,
   output logic             BEN,
   output logic [WIDTH-1:0] IR_OUT,
   output logic [WIDTH-1:0] PC_OUT,
   output logic [WIDTH-1:0] MAR_OUT,
   output logic [WIDTH-1:0] MDR_OUT,
   output logic [LED_W-1:0] LED
);

   logic [WIDTH-1:0] pc_reg, ir_reg, mar_reg, mdr_reg;
   logic [WIDTH-1:0] rf_reg [8];
   logic [2:0]       nzp_reg;
   logic             ben_reg;
   logic [LED_W-1:0] led_reg;
   logic             conflict_reg;

   logic [WIDTH-1:0] bus, alu_out, alu_b, sr1_val, sr2_val;
   logic [WIDTH-1:0] addr1, addr2, addr_sum, pc_next;
   logic [WIDTH-1:0] sext11, sext9, sext6, sext5;
   logic [2:0]       sr1_idx, sr2_idx, dr_idx;
   logic [7:0]       rf_we;
   logic             multi_gate, rd_load;

   lc3_mem_engine #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem (
      .clk       (clk),
      .reset     (reset),
      .mem_start (mem_start),
      .mem_we    (mem_we),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_busy  (mem_busy),
      .mem_done  (mem_done),
      .mem_err   (mem_err),
      .rd_load   (rd_load)
   );

   assign sext11 = {{(WIDTH-11){ir_reg[10]}}, ir_reg[10:0]};
   assign sext9  = {{(WIDTH-9){ir_reg[8]}},   ir_reg[8:0]};
   assign sext6  = {{(WIDTH-6){ir_reg[5]}},   ir_reg[5:0]};
   assign sext5  = {{(WIDTH-5){ir_reg[4]}},   ir_reg[4:0]};

   assign sr1_idx = SR1MUX ? ir_reg[8:6] : ir_reg[11:9];
   assign sr2_idx = ir_reg[2:0];
   assign dr_idx  = DRMUX ? R7 : ir_reg[11:9];
   assign sr1_val = rf_reg[sr1_idx];
   assign sr2_val = rf_reg[sr2_idx];
   assign alu_b   = SR2MUX ? sr2_val : sext5;

   for (genvar gi = 0; gi < 8; gi++) begin : g_rf_we
      assign rf_we[gi] = LD_REG && (dr_idx == 3'(gi));
   end

   always_comb begin
      alu_out = '0;
      case (aluk_t'(ALUK))
         ALU_ADD:  alu_out = sr1_val + alu_b;
         ALU_AND:  alu_out = sr1_val & alu_b;
         ALU_NOT:  alu_out = ~sr1_val;
         ALU_PASS: alu_out = sr1_val;
         default:  alu_out = sr1_val;
      endcase
   end

   always_comb begin
      addr2 = '0;
      case (addr2mux_t'(ADDR2MUX))
         A2_OFF11: addr2 = sext11;
         A2_OFF9:  addr2 = sext9;
         A2_OFF6:  addr2 = sext6;
         default:  addr2 = '0;
      endcase
   end

   assign addr1    = ADDR1MUX ? sr1_val : pc_reg;
   assign addr_sum = addr1 + addr2;

   always_comb begin
      pc_next = pc_reg;
      case (pcmux_t'(PCMUX))
         PC_INC:  pc_next = pc_reg + 1'b1;
         PC_BUS:  pc_next = bus;
         PC_ADDR: pc_next = addr_sum;
         default: pc_next = pc_reg;
      endcase
   end

   // The bus is a priority mux rather than a tristate; collisions are flagged.
   always_comb begin
      if (GateMARMUX)   bus = addr_sum;
      else if (GatePC)  bus = pc_reg;
      else if (GateMDR) bus = mdr_reg;
      else if (GateALU) bus = alu_out;
      else              bus = '0;
   end

   assign multi_gate = (GateMARMUX & (GatePC | GateMDR | GateALU))
                     | (GatePC & (GateMDR | GateALU))
                     | (GateMDR & GateALU);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg       <= PC_RESET;
         ir_reg       <= '0;
         mar_reg      <= '0;
         mdr_reg      <= '0;
         nzp_reg      <= 3'b010;
         ben_reg      <= 1'b0;
         led_reg      <= '0;
         conflict_reg <= 1'b0;
         for (int i = 0; i < 8; i++)
            rf_reg[i] <= '0;
      end else begin
         if (LD_PC) pc_reg <= pc_next;
         if (LD_IR) ir_reg <= bus;
         // MAR and MDR are frozen while a transaction owns them.
         if (LD_MAR && !mem_busy) mar_reg <= bus;
         if (rd_load)
            mdr_reg <= mem_rdata;
         else if (LD_MDR && !mem_busy)
            mdr_reg <= bus;
         if (LD_CC)
            nzp_reg <= {bus[WIDTH-1], ~|bus, ~bus[WIDTH-1] & (|bus)};
         if (LD_BEN) ben_reg <= |(ir_reg[11:9] & nzp_reg);
         if (LD_LED) led_reg <= ir_reg[LED_W-1:0];
         if (multi_gate) conflict_reg <= 1'b1;
         for (int i = 0; i < 8; i++)
            if (rf_we[i]) rf_reg[i] <= bus;
      end
   end

   assign mem_addr     = mar_reg;
   assign mem_wdata    = mdr_reg;
   assign bus_conflict = conflict_reg;
   assign BEN          = ben_reg;
   assign IR_OUT       = ir_reg;
   assign PC_OUT       = pc_reg;
   assign MAR_OUT      = mar_reg;
   assign MDR_OUT      = mdr_reg;
   assign LED          = led_reg;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Directed plus randomized bench for lc3_datapath_gen; expected values come
// from a small arithmetic model of the architectural state.
module tb_lc3_datapath_gen;

   localparam int          W   = 16;
   localparam logic [15:0] PCR = 16'h3000;
   localparam int          TO  = 4;

   logic clk = 1'b0;
   logic reset;
   logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic ADDR1MUX, SR1MUX, SR2MUX, DRMUX;
   logic mem_start, mem_we, mem_req, mem_wr, mem_ack, mem_busy, mem_done, mem_err;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic bus_conflict, BEN;
   logic [W-1:0] IR_OUT, PC_OUT, MAR_OUT, MDR_OUT;
   logic [11:0] LED;

   always #5 clk = ~clk;

   lc3_datapath_gen #(.WIDTH(W), .PC_RESET(PCR), .LED_W(12), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX),
      .SR2MUX(SR2MUX), .DRMUX(DRMUX), .ALUK(ALUK),
      .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
      .bus_conflict(bus_conflict), .BEN(BEN),
      .IR_OUT(IR_OUT), .PC_OUT(PC_OUT), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT), .LED(LED)
   );

   int tests = 0;
   int fails = 0;

   // Architectural model
   logic [15:0] m_pc, m_ir, m_mar, m_mdr;
   logic [15:0] m_rf [8];
   logic [2:0]  m_nzp;

   function automatic logic [15:0] sx(input logic [15:0] v, input int n);
      int s;
      s = int'(v) & ((1 << n) - 1);
      if (s >= (1 << (n - 1))) s = s - (1 << n);
      return 16'(s);
   endfunction

   function automatic logic [2:0] cc(input logic [15:0] v);
      if (v[15]) return 3'b100;
      if (v == 16'h0) return 3'b010;
      return 3'b001;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ctl();
      {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
      {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
      {PCMUX, ADDR2MUX, ALUK} = '0;
      {ADDR1MUX, SR1MUX, SR2MUX, DRMUX} = '0;
      {mem_start, mem_we, mem_ack} = '0;
   endtask

   task automatic model_reset();
      m_pc = PCR; m_ir = 0; m_mar = 0; m_mdr = 0; m_nzp = 3'b010;
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
   endtask

   // One memory transaction observed over a fixed window; ack_at = REQ cycle
   // that sees the ack (0 = never). poke drives illegal loads/starts while busy.
   task automatic mem_txn(input logic we, input int ack_at, input logic [15:0] rdata,
                          input bit poke, output int req_n, output int done_n,
                          output int done_at, output int bad);
      mem_start = 1'b1; mem_we = we;
      tick();
      clr_ctl();
      req_n = 0; done_n = 0; done_at = 0; bad = 0;
      for (int c = 1; c <= TO + 4; c++) begin
         if (mem_req) begin
            req_n++;
            if (mem_addr !== m_mar || mem_wdata !== m_mdr || mem_wr !== we) bad++;
         end
         if (mem_done) begin
            done_n++;
            done_at = c;
         end
         if (mem_req && req_n == ack_at) begin
            mem_ack = 1'b1; mem_rdata = rdata;
         end else if (mem_done) begin
            mem_ack = 1'b1; mem_rdata = ~rdata;
         end
         if (poke && mem_busy) begin
            mem_start = 1'b1; mem_we = ~we;
            GatePC = 1'b1; LD_MAR = 1'b1; LD_MDR = 1'b1;
         end
         tick();
         clr_ctl();
      end
      if (!we && ack_at != 0) m_mdr = rdata;
   endtask

   task automatic load_mdr(input logic [15:0] v);
      int a, b, c, d;
      mem_txn(1'b0, 1, v, 1'b0, a, b, c, d);
   endtask

   task automatic set_ir(input logic [15:0] v);
      load_mdr(v);
      GateMDR = 1'b1; LD_IR = 1'b1;
      tick(); clr_ctl();
      m_ir = v;
   endtask

   task automatic set_reg(input int r, input logic [15:0] v);
      set_ir(16'(r << 9));
      load_mdr(v);
      GateMDR = 1'b1; LD_REG = 1'b1;
      tick(); clr_ctl();
      m_rf[r] = v;
   endtask

   task automatic read_reg(input int r, input string tag);
      set_ir(16'(r << 6));
      SR1MUX = 1'b1; ALUK = 2'd3; GateALU = 1'b1; LD_MDR = 1'b1;
      tick(); clr_ctl();
      m_mdr = m_rf[r];
      check(tag, MDR_OUT, m_rf[r]);
   endtask

   task automatic check_ben(input logic [2:0] mask, input string tag);
      set_ir({4'h0, mask, 9'h0});
      LD_BEN = 1'b1;
      tick(); clr_ctl();
      check(tag, BEN, 32'(|(mask & m_nzp)));
   endtask

   task automatic alu_op(input int dr, input int sr1, input int sr2, input int k,
                         input bit use_sr2, input logic [4:0] imm);
      logic [15:0] ir, a, b, r;
      ir = {4'h1, 3'(dr), 3'(sr1), 1'b0, imm};
      if (use_sr2) ir[2:0] = 3'(sr2);
      a = m_rf[sr1];
      b = use_sr2 ? m_rf[ir[2:0]] : sx({11'h0, ir[4:0]}, 5);
      case (k)
         0:       r = a + b;
         1:       r = a & b;
         2:       r = ~a;
         default: r = a;
      endcase
      set_ir(ir);
      SR1MUX = 1'b1; SR2MUX = use_sr2; ALUK = 2'(k);
      GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      tick(); clr_ctl();
      m_rf[dr] = r;
      m_nzp = cc(r);
   endtask

   initial begin
      int rq, dn, dat, bad;
      logic [15:0] v, exp_addr;
      logic [1:0]  a2;
      logic        a1;

      clr_ctl();
      mem_rdata = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      model_reset();

      check("rst_pc", PC_OUT, PCR);
      check("rst_ir", IR_OUT, 0);
      check("rst_mar", MAR_OUT, 0);
      check("rst_mdr", MDR_OUT, 0);
      check("rst_led", LED, 0);
      check("rst_ben", BEN, 0);
      check("rst_mem", {mem_req, mem_busy, mem_done, mem_err, bus_conflict}, 0);

      for (int i = 0; i < 3; i++) begin
         LD_PC = 1'b1; PCMUX = 2'd0;
         tick(); clr_ctl();
         m_pc = m_pc + 1;
      end
      check("pc_inc3", PC_OUT, PCR + 16'd3);

      check_ben(3'b010, "rst_nzp_z");
      check_ben(3'b101, "rst_nzp_np");

      // NOT R0 (=0) puts all-ones on the bus for the wrap test
      set_ir(16'h0000);
      SR1MUX = 1'b1; ALUK = 2'd2; GateALU = 1'b1; LD_PC = 1'b1; PCMUX = 2'd1;
      tick(); clr_ctl();
      m_pc = 16'hFFFF;
      check("pc_bus_ffff", PC_OUT, m_pc);
      LD_PC = 1'b1; PCMUX = 2'd0;
      tick(); clr_ctl();
      m_pc = m_pc + 1;
      check("pc_wrap", PC_OUT, 16'h0000);
      LD_PC = 1'b1; PCMUX = 2'd3;
      tick(); clr_ctl();
      check("pc_hold", PC_OUT, m_pc);

      // Read: MAR=0x0040, ack on third REQ cycle
      load_mdr(16'h0040);
      GateMDR = 1'b1; LD_MAR = 1'b1;
      tick(); clr_ctl();
      m_mar = 16'h0040;
      check("mar_load", MAR_OUT, 16'h0040);
      mem_txn(1'b0, 3, 16'hBEEF, 1'b0, rq, dn, dat, bad);
      $display("[TB] read  addr=%h req_cycles=%0d done_pulses=%0d done_at=%0d mdr=%h", m_mar, rq, dn, dat, MDR_OUT);
      check("rd_req_cycles", rq, 3);
      check("rd_done_pulses", dn, 1);
      check("rd_done_at", dat, 4);
      check("rd_bus_stable", bad, 0);
      check("rd_mdr", MDR_OUT, 16'hBEEF);
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      tick(); clr_ctl();
      check("idle_ack_ignored", {mem_busy, MDR_OUT}, {1'b0, 16'hBEEF});

      // Write with first-cycle ack plus illegal start/loads while busy
      load_mdr(16'h1234);
      mem_txn(1'b1, 1, 16'h0000, 1'b1, rq, dn, dat, bad);
      $display("[TB] write addr=%h req_cycles=%0d done_pulses=%0d done_at=%0d", m_mar, rq, dn, dat);
      check("wr_req_cycles", rq, 1);
      check("wr_done_pulses", dn, 1);
      check("wr_done_at", dat, 2);
      check("wr_bus_stable", bad, 0);
      check("wr_mdr_kept", MDR_OUT, 16'h1234);
      check("wr_mar_kept", MAR_OUT, 16'h0040);
      check("wr_no_err", mem_err, 0);

      // Timeout: no ack ever
      mem_txn(1'b0, 0, 16'hDEAD, 1'b1, rq, dn, dat, bad);
      $display("[TB] tmo   addr=%h req_cycles=%0d done_pulses=%0d done_at=%0d err=%b", m_mar, rq, dn, dat, mem_err);
      check("to_req_cycles", rq, TO);
      check("to_done_pulses", dn, 1);
      check("to_done_at", dat, TO + 1);
      check("to_bus_stable", bad, 0);
      check("to_mdr_kept", MDR_OUT, 16'h1234);
      check("to_err_idle", {mem_err, mem_busy}, 2'b10);

      // ALU directed
      set_reg(1, 16'h7FFF);
      set_reg(2, 16'h0001);
      alu_op(0, 1, 2, 0, 1'b1, 5'h0);
      read_reg(0, "add_r0");
      check_ben(3'b100, "add_ben_n");
      check_ben(3'b011, "add_ben_zp");
      alu_op(3, 0, 0, 2, 1'b0, 5'h0);
      read_reg(3, "not_r0");
      check_ben(3'b001, "not_ben_p");
      check_ben(3'b110, "not_ben_nz");

      // Randomized ALU, address-sum and LED traffic
      for (int it = 0; it < 12; it++) begin
         set_reg($urandom_range(0, 7), 16'($urandom));
         set_reg($urandom_range(0, 7), 16'($urandom));
         alu_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3), 1'($urandom), 5'($urandom));
         $display("[TB] alu   it=%0d ir=%h nzp=%b", it, m_ir, m_nzp);
         check_ben(3'($urandom), "rnd_ben");
         read_reg(m_ir[11:9], "rnd_alu");

         set_ir(16'($urandom));
         a1 = 1'($urandom);
         a2 = 2'($urandom);
         case (a2)
            2'd0:    v = sx(m_ir, 11);
            2'd1:    v = sx(m_ir, 9);
            2'd2:    v = sx(m_ir, 6);
            default: v = 16'h0;
         endcase
         exp_addr = (a1 ? m_rf[m_ir[8:6]] : m_pc) + v;
         ADDR1MUX = a1; ADDR2MUX = a2; SR1MUX = 1'b1;
         PCMUX = 2'd2; LD_PC = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1; LD_LED = 1'b1;
         tick(); clr_ctl();
         m_pc = exp_addr; m_mar = exp_addr;
         $display("[TB] addr  it=%0d ir=%h a1=%0d a2=%0d sum=%h", it, m_ir, a1, a2, exp_addr);
         check("rnd_pc_sum", PC_OUT, exp_addr);
         check("rnd_mar_sum", MAR_OUT, exp_addr);
         check("rnd_led", LED, m_ir[11:0]);
      end
      check("no_conflict_yet", bus_conflict, 0);

      // Bus conflict: PC wins over ALU, flag is sticky
      GatePC = 1'b1; GateALU = 1'b1; LD_MAR = 1'b1;
      tick(); clr_ctl();
      m_mar = m_pc;
      check("conf_bus_pc", MAR_OUT, m_pc);
      check("conf_set", bus_conflict, 1);
      tick(); tick(); tick();
      check("conf_sticky", bus_conflict, 1);

      // Reset while in REQ with a coincident ack
      mem_start = 1'b1;
      tick(); clr_ctl();
      tick();
      check("req_before_rst", mem_req, 1);
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h5555;
      tick();
      reset = 1'b0; clr_ctl();
      model_reset();
      $display("[TB] reset mid-REQ req=%b busy=%b mdr=%h", mem_req, mem_busy, MDR_OUT);
      check("rst_req_drop", {mem_req, mem_busy}, 2'b00);
      check("rst_flags", {mem_err, bus_conflict, BEN}, 3'b000);
      check("rst_mdr_noload", MDR_OUT, 16'h0000);
      check("rst_pc2", PC_OUT, PCR);
      tick();
      check("rst_no_done", mem_done, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lc3_datapath_gen.md
Name: lc3_datapath_gen

Overview:
Parametrised next-generation LC-3 datapath holding PC, IR, MAR, MDR, register file, ALU, condition codes/BEN, LED latch and the internal bus, all driven by the existing control FSM. It replaces the fixed MEMIO select with its own memory handshake engine, which supports variable-latency memory, timeouts and bus-conflict detection. Data width and timeout depth are generic; the 16-bit instruction format is unchanged.

Parameters:
WIDTH, 16, datapath/bus width (>=16); IR fields always taken from IR[15:0]
PC_RESET, 0, PC value after reset
LED_W, 12, LED latch width (<=WIDTH), loaded from IR[LED_W-1:0]
MEM_TIMEOUT, 255, max cycles waiting for mem_ack before abort (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers
PCMUX  in  2  0:PC+1, 1:bus, 2:addr sum, 3:hold PC
ADDR2MUX  in  2  0:SEXT(IR[10:0]), 1:SEXT(IR[8:0]), 2:SEXT(IR[5:0]), 3:0
ADDR1MUX, SR1MUX, SR2MUX, DRMUX  in  1 each  see Behaviour
ALUK  in  2  0:ADD, 1:AND, 2:NOT A, 3:PASS A
mem_start  in  1  one-cycle request to start a memory transaction
mem_we  in  1  sampled with mem_start: 1 = write MDR to M[MAR]
mem_req  out  1  request to memory, held until ack
mem_wr  out  1  write qualifier, valid while mem_req
mem_addr, mem_wdata  out  WIDTH  MAR, MDR
mem_rdata  in  WIDTH  read data, valid on mem_ack
mem_ack  in  1  memory completion strobe
mem_busy  out  1  transaction in flight
mem_done  out  1  one-cycle pulse on completion or abort
mem_err  out  1  sticky timeout flag
bus_conflict  out  1  sticky: >1 gate active on the same cycle
BEN  out  1  branch enable
IR_OUT, PC_OUT, MAR_OUT, MDR_OUT  out  WIDTH  register contents
LED  out  LED_W  LED latch

Behaviour:
- Reset (synchronous): PC=PC_RESET; IR/MAR/MDR/R0-R7/LED=0; nzp=3'b010; BEN=0; FSM=IDLE; mem_req/mem_busy/mem_done/mem_err/bus_conflict=0.
- Bus: bus priority is MARMUX > PC > MDR > ALU, and the bus is 0 when no gate is active. If two or more gates are active, bus_conflict sets and holds until reset.
- Sign extension: all SEXT results are sign-extended to WIDTH. Addr sum = ADDR1 (0:PC, 1:SR1) + ADDR2, modulo 2^WIDTH. PC+1 wraps from all-ones to 0.
- Register file: 8 regs. SR1 = SR1MUX ? IR[8:6] : IR[11:9]. SR2 = IR[2:0]. DR = DRMUX ? R7 : IR[11:9]. Writes take effect on the clock edge with LD_REG. Reads are combinational and return the old value during the write cycle.
- ALU: B = SR2MUX ? SR2 : SEXT(IR[4:0]).
- Condition codes: on LD_CC, nzp comes from the bus: N = bus[WIDTH-1], Z = (bus==0), P = otherwise. On LD_BEN, BEN <= |(IR[11:9] & nzp), using the current registered nzp.
- Memory FSM, IDLE -> REQ -> DONE -> IDLE:
  - IDLE: mem_start latches mem_we and moves to REQ. mem_req asserts the next cycle and stays high with stable mem_addr/mem_wdata.
  - REQ: a wait counter increments each cycle. On mem_ack: for a read, MDR <= mem_rdata; go to DONE. An ack in the first REQ cycle is legal, giving 2-cycle minimum latency start->done.
  - Timeout: if the counter reaches MEM_TIMEOUT without ack, mem_err sets and the FSM goes to DONE with MDR unchanged.
  - DONE: mem_done=1 for one cycle, mem_req=0, then IDLE.
  - mem_busy = (state != IDLE).
- Boundary rules:
  - mem_start while busy is ignored.
  - LD_MDR from the bus while busy is ignored.
  - LD_MAR while busy is ignored, so the address stays stable.
  - mem_ack in IDLE/DONE is ignored.
  - Reset in REQ drops mem_req at the next edge; no MDR update.
- LED: on LD_LED, LED <= IR[LED_W-1:0].

Decomposition:
- Package lc3_gen_pkg: ALUK/PCMUX/ADDR2MUX enum typedefs, mem_state_t {IDLE,REQ,DONE}, R7 index constant.
- One natural sub-module: lc3_mem_engine (FSM, timeout counter, MDR read-load strobe).
- Register file inline or as the existing register unit generalised to WIDTH.

Test Plan:
- Reset, then LD_PC with PCMUX=0 three times -> PC_OUT = PC_RESET+3. With PC=16'hFFFF, PC+1 -> 16'h0000.
- MAR=16'h0040, mem_start with we=0, ack after 3 cycles with rdata=16'hBEEF -> MDR=16'hBEEF, mem_done pulses exactly once, mem_req high for 3 cycles.
- Write with MDR=16'h1234, ack in first REQ cycle -> mem_wr=1, mem_wdata=16'h1234, done 2 cycles after start; second mem_start while busy produces no extra transaction.
- MEM_TIMEOUT=4, never ack -> mem_err=1 after 4 REQ cycles, mem_done pulses, MDR unchanged, FSM back in IDLE.
- ALU path: R1=16'h7FFF, R2=1, ADD gated with LD_CC -> R0=16'h8000, nzp=100. IR[11:9]=100, LD_BEN -> BEN=1; NOT R0 -> 16'h7FFF, nzp=001.
- GatePC and GateALU in the same cycle -> bus=PC, bus_conflict=1 and stays set until reset. Reset mid-REQ -> mem_req=0 and mem_busy=0 next cycle.
